// File: rtl/design_select_sequencer.sv
// Routes the shared pad IO to one of NUM_DESIGNS slots and sequences slot changes (debounce, gate, reset pulse, hand-over).
// Optional DESMUX_SYNC_EN: two-flop synchronizers on des_sel/hold_if_not_sel instead of a single sampling register.
module design_select_sequencer #(
   parameter int unsigned NUM_DESIGNS   = 64,
   parameter int unsigned IO_W          = 12,
   parameter int unsigned SEL_W         = 6,
   parameter int unsigned STABLE_CYCLES = 4,
   parameter int unsigned RST_CYCLES    = 8
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic [SEL_W-1:0]            des_sel,
   input  logic                        hold_if_not_sel,
   input  logic [IO_W-1:0]             io_in,
   output logic [IO_W-1:0]             io_out,
   output logic [NUM_DESIGNS*IO_W-1:0] des_io_in,
   input  logic [NUM_DESIGNS*IO_W-1:0] des_io_out,
   output logic [NUM_DESIGNS-1:0]      des_reset,
   output logic [SEL_W-1:0]            active_sel,
   output logic                        switching
);

   localparam logic [1:0] ST_RUN    = 2'd0;
   localparam logic [1:0] ST_SETTLE = 2'd1;
   localparam logic [1:0] ST_PULSE  = 2'd2;

   localparam int unsigned CNT_MAX = (STABLE_CYCLES > RST_CYCLES) ? STABLE_CYCLES : RST_CYCLES;
   localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] PULSE_LAST  = CNT_W'(RST_CYCLES - 1);

   logic [1:0]             state;
   logic [CNT_W-1:0]       cnt;
   logic [SEL_W-1:0]       pending;
   logic [SEL_W-1:0]       sel_q;
   logic                   hold_q;
   logic [NUM_DESIGNS-1:0] des_reset_d;
   logic [IO_W-1:0]        slot_out;

`ifdef DESMUX_SYNC_EN
   logic [SEL_W-1:0] sel_meta;
   logic             hold_meta;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sel_meta  <= '0;
         hold_meta <= 1'b1;
         sel_q     <= '0;
         hold_q    <= 1'b1;
      end else begin
         sel_meta  <= des_sel;
         hold_meta <= hold_if_not_sel;
         sel_q     <= sel_meta;
         hold_q    <= hold_meta;
      end
   end
`else
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sel_q  <= '0;
         hold_q <= 1'b1;
      end else begin
         sel_q  <= des_sel;
         hold_q <= hold_if_not_sel;
      end
   end
`endif

   // A mismatch in SETTLE takes priority over expiry, so a late change restarts the window.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= ST_PULSE;
         cnt        <= '0;
         pending    <= '0;
         active_sel <= '0;
      end else begin
         case (state)
            ST_RUN: begin
               if (sel_q != active_sel) begin
                  pending <= sel_q;
                  cnt     <= '0;
                  state   <= ST_SETTLE;
               end
            end
            ST_SETTLE: begin
               if (sel_q != pending) begin
                  pending <= sel_q;
                  cnt     <= '0;
               end else if (cnt == STABLE_LAST) begin
                  cnt <= '0;
                  if (pending == active_sel) begin
                     state <= ST_RUN;
                  end else begin
                     active_sel <= pending;
                     state      <= ST_PULSE;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_PULSE: begin
               if (cnt == PULSE_LAST) begin
                  cnt   <= '0;
                  state <= ST_RUN;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               cnt   <= '0;
               state <= ST_RUN;
            end
         endcase
      end
   end

   assign switching = (state != ST_RUN);

   // Out-of-range active_sel matches no slot, so every bit falls back to hold_q and io_out stays 0.
   always_comb begin
      des_reset_d = '0;
      slot_out    = '0;
      des_io_in   = '0;
      for (int unsigned i = 0; i < NUM_DESIGNS; i++) begin
         if (SEL_W'(i) == active_sel) begin
            des_reset_d[i] = (state == ST_PULSE);
            slot_out       = des_io_out[i*IO_W +: IO_W];
            if (state == ST_RUN) begin
               des_io_in[i*IO_W +: IO_W] = io_in;
            end
         end else begin
            des_reset_d[i] = hold_q;
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         des_reset <= '1;
         io_out    <= '0;
      end else begin
         des_reset <= des_reset_d;
         io_out    <= (state == ST_RUN) ? slot_out : '0;
      end
   end

endmodule

// File: tb/tb_design_select_sequencer.sv
// Scoreboard bench for design_select_sequencer: stimulus pushes expected switch outcomes, a negedge monitor checks them.
module tb_design_select_sequencer;

   localparam int unsigned NUM   = 40;
   localparam int unsigned IO_W  = 12;
   localparam int unsigned SEL_W = 6;
   localparam int unsigned S     = 4;
   localparam int unsigned R     = 8;
   localparam logic [63:0] ALL   = (64'd1 << NUM) - 64'd1;

   logic                 clock = 1'b0;
   logic                 reset = 1'b1;
   logic [SEL_W-1:0]     des_sel = '0;
   logic                 hold_if_not_sel = 1'b1;
   logic [IO_W-1:0]      io_in = '0;
   logic [IO_W-1:0]      io_out;
   logic [NUM*IO_W-1:0]  des_io_in;
   logic [NUM*IO_W-1:0]  des_io_out = '0;
   logic [NUM-1:0]       des_reset;
   logic [SEL_W-1:0]     active_sel;
   logic                 switching;

   design_select_sequencer #(
      .NUM_DESIGNS(NUM),
      .IO_W(IO_W),
      .SEL_W(SEL_W),
      .STABLE_CYCLES(S),
      .RST_CYCLES(R)
   ) dut (
      .clock(clock),
      .reset(reset),
      .des_sel(des_sel),
      .hold_if_not_sel(hold_if_not_sel),
      .io_in(io_in),
      .io_out(io_out),
      .des_io_in(des_io_in),
      .des_io_out(des_io_out),
      .des_reset(des_reset),
      .active_sel(active_sel),
      .switching(switching)
   );

   always #5 clock = ~clock;

   typedef struct {
      int unsigned active;
      int unsigned dur;
      int unsigned pulse;
      logic [IO_W-1:0] io;
   } exp_t;

   exp_t            sb[$];
   logic [IO_W-1:0] pat [64];
   int              n_tests = 0;
   int              n_fail  = 0;
   bit              mon_en  = 1'b0;
   int unsigned     cur_sel = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   function automatic void push_exp(input int unsigned act, input int unsigned dur, input int unsigned pulse);
      exp_t e;
      e.active = act;
      e.dur    = dur;
      e.pulse  = pulse;
      e.io     = (act < NUM) ? pat[act] : '0;
      sb.push_back(e);
   endfunction

   initial begin
      forever begin
         @(posedge clock);
         #2 io_in = IO_W'($urandom);
      end
   end

   // Monitor: per-cycle routing checks plus one scoreboard pop per completed switch window.
   bit          in_sw, prev_sw, post_io;
   int unsigned dur_n, pulse_n, m_active, hold_age;
   logic        last_hold;
   exp_t        cur;

   always @(negedge clock) begin
      if (!mon_en) begin
         in_sw     = 1'b0;
         prev_sw   = 1'b1;
         post_io   = 1'b0;
         m_active  = 0;
         hold_age  = 0;
         last_hold = hold_if_not_sel;
      end else begin
         logic [IO_W-1:0]  oth;
         logic [63:0]      exp_rst;
         if (hold_if_not_sel == last_hold) hold_age++;
         else begin
            hold_age  = 0;
            last_hold = hold_if_not_sel;
         end
         if (post_io) begin
            check("io_out_after_switch", io_out, cur.io);
            post_io = 1'b0;
         end
         if (switching) begin
            if (!in_sw) begin
               in_sw   = 1'b1;
               dur_n   = 0;
               pulse_n = 0;
            end
            dur_n++;
            if (des_reset != '0) pulse_n++;
            if (prev_sw) check("io_out_gated", io_out, '0);
         end else if (in_sw) begin
            in_sw = 1'b0;
            if (des_reset != '0) pulse_n++;
            if (sb.size() == 0) begin
               check("unexpected_switch", sb.size(), 1);
            end else begin
               cur = sb.pop_front();
               check("active_sel", active_sel, cur.active);
               check("switch_cycles", dur_n, cur.dur);
               check("pulse_cycles", pulse_n, cur.pulse);
               m_active = cur.active;
               post_io  = 1'b1;
            end
         end
         oth = '0;
         for (int i = 0; i < NUM; i++)
            if (switching || i != m_active) oth |= des_io_in[i*IO_W +: IO_W];
         check("des_io_in_idle_slots", oth, '0);
         if (!switching && m_active < NUM)
            check("des_io_in_active", des_io_in[m_active*IO_W +: IO_W], io_in);
         if (!switching && !prev_sw && hold_age >= 3) begin
            exp_rst = hold_if_not_sel ? ALL : 64'd0;
            if (m_active < NUM) exp_rst[m_active] = 1'b0;
            check("des_reset_run", des_reset, exp_rst);
         end
         prev_sw = switching;
      end
   end

   task automatic wait_idle(input string name);
      int unsigned k = 0;
      do begin
         @(negedge clock);
         k++;
      end while ((sb.size() != 0 || switching) && k < 200);
      @(negedge clock);
      @(negedge clock);
      check(name, (k < 200), 1);
   endtask

   task automatic do_switch(input int unsigned target);
      push_exp(target, S + R, (target < NUM) ? R : 0);
      des_sel = SEL_W'(target);
      cur_sel = target;
      wait_idle("switch_done");
   endtask

   task automatic do_glitch(input int unsigned target, input int unsigned g);
      push_exp(cur_sel, g + S, 0);
      des_sel = SEL_W'(target);
      repeat (g) @(negedge clock);
      des_sel = SEL_W'(cur_sel);
      wait_idle("glitch_done");
   endtask

   initial begin
      for (int i = 0; i < 64; i++) pat[i] = IO_W'(i * 149 + 83) ^ 12'h5C3;
      pat[11] = 12'hA5A;
      for (int i = 0; i < NUM; i++) des_io_out[i*IO_W +: IO_W] = pat[i];

      repeat (3) @(negedge clock);
      check("rst_des_reset", des_reset, ALL);
      check("rst_io_out", io_out, '0);
      check("rst_switching", switching, 1);
      check("rst_active_sel", active_sel, 0);

      reset = 1'b0;
      for (int k = 1; k <= 9; k++) begin
         @(negedge clock);
         if (k <= 8) begin
            check("release_des_reset", des_reset, ALL);
            check("release_switching", switching, (k < 8));
         end else begin
            check("release_des_reset_run", des_reset, ALL & ~64'd1);
            check("release_io_out", io_out, pat[0]);
         end
      end

      hold_if_not_sel = 1'b0;
      repeat (4) @(negedge clock);
      check("hold_off_des_reset", des_reset, '0);

      mon_en = 1'b1;
      @(negedge clock);
      do_glitch(5, 2);
      do_switch(11);

      // Request 3 then 7 while 3 is still in its reset pulse.
      push_exp(3, S + R, R);
      push_exp(7, S + R, R);
      des_sel = SEL_W'(3);
      repeat (S + 6) @(negedge clock);
      des_sel = SEL_W'(7);
      cur_sel = 7;
      wait_idle("chain_done");

      do_switch(63);
      do_switch(2);

      for (int n = 0; n < 30; n++) begin
         int unsigned tgt;
         tgt = (cur_sel + 1 + $urandom_range(0, 62)) % 64;
         if ($urandom_range(0, 3) == 0) do_glitch(tgt, $urandom_range(1, S - 1));
         else do_switch(tgt);
      end

      mon_en = 1'b0;
      des_sel = SEL_W'(9);
      repeat (S + 6) @(negedge clock);
      #2 reset = 1'b1;
      #1;
      check("abort_des_reset", des_reset, ALL);
      check("abort_io_out", io_out, '0);
      check("abort_switching", switching, 1);
      check("abort_active_sel", active_sel, 0);
      des_sel = '0;
      cur_sel = 0;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      repeat (R + 5) @(negedge clock);
      check("reacquire_active_sel", active_sel, 0);
      check("reacquire_des_reset", des_reset, '0);
      check("reacquire_io_out", io_out, pat[0]);

      mon_en = 1'b1;
      @(negedge clock);
      do_switch(20);
      do_glitch(33, S - 1);
      do_switch(0);

      check("scoreboard_drained", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/design_select_sequencer.md
# design_select_sequencer

Parametrised successor to the chip-level design multiplexer. It routes the shared IO pins to one of `NUM_DESIGNS` design slots, and manages selection changes with a cycle-accurate sequence:

- debounce the new select value;
- gate all IO during the switch;
- pulse a dedicated reset into the newly selected design;
- hand over the IO pins.

It sits between the top-level pads and the per-slot design instantiations, replacing the purely combinational mux.

## Interface

Parameters:
- `NUM_DESIGNS`, default 64: number of design slots.
- `IO_W`, default 12: per-slot IO width, in each direction.
- `SEL_W`, default 6: select width; must satisfy `2**SEL_W >= NUM_DESIGNS`.
- `STABLE_CYCLES`, default 4: number of consecutive cycles the sampled select must hold before a switch is accepted; minimum 1.
- `RST_CYCLES`, default 8: length of the reset pulse driven into a newly selected design; minimum 1.

Ports:
- `clock` input 1: sole clock; every flop in the block runs on it.
- `reset` input 1: asynchronous, active-high.
- `des_sel` input `SEL_W`: requested design slot; asynchronous to `clock` (from pads).
- `hold_if_not_sel` input 1: 1 = unselected slots are held in reset.
- `io_in` input `IO_W`: pad inputs.
- `io_out` output `IO_W`: pad outputs; registered.
- `des_io_in` output `NUM_DESIGNS*IO_W`: slot i is bits `[i*IO_W +: IO_W]`.
- `des_io_out` input `NUM_DESIGNS*IO_W`: slot outputs, same packing.
- `des_reset` output `NUM_DESIGNS`: per-slot reset; registered.
- `active_sel` output `SEL_W`: slot currently owning the pins.
- `switching` output 1: high in every state other than RUN.

## Operation

Input sampling:
- `des_sel` and `hold_if_not_sel` are registered into `sel_q` and `hold_q`.
- The sample latency depends on the configuration macro below.

State machine:
- **RUN**
  - If `sel_q != active_sel`: load `pending = sel_q`, clear the counter, go to SETTLE.
- **SETTLE**
  - If `sel_q != pending`: reload `pending = sel_q` and clear the counter; the window restarts.
  - Otherwise the counter increments.
  - When the counter reaches `STABLE_CYCLES-1` with a match: `active_sel <= pending`, clear the counter, go to PULSE.
  - If `pending == active_sel` when the counter expires, go to RUN directly without a pulse (a glitch that returned to the original value).
- **PULSE**
  - Counts `RST_CYCLES` cycles, then goes to RUN.
  - Changes on `sel_q` are ignored until RUN; they are detected on the first RUN cycle.

Routing and reset behaviour:
- **`des_reset[i]` (registered):**
  - 1 when `i == active_sel` and state is PULSE.
  - 0 when `i == active_sel` and state is RUN.
  - 0 when `i == active_sel` and state is SETTLE, because the old design keeps running while IO is gated.
  - Equal to `hold_q` for every `i != active_sel`.
- **`des_io_in` (combinational):** slot `active_sel` gets `io_in` only in RUN; all other slots, and all slots in any other state, get 0.
- **`io_out` (registered):** next value is `des_io_out[active_sel]` in RUN, else 0.
- **Out-of-range select:** a value `active_sel >= NUM_DESIGNS` is a legal unpopulated slot.
  - `io_out` stays 0.
  - No `des_reset` bit is pulsed.
  - All `des_reset` bits follow `hold_q`.

Reset values:
- State = PULSE, counter = 0.
- `active_sel` = 0, `pending` = 0, `sel_q` = 0, `hold_q` = 1.
- `des_reset` = all ones, `io_out` = 0, `switching` = 1.
- After `reset` falls: `RST_CYCLES` cycles of PULSE on slot 0, then RUN. If the pins request another slot, the normal switch sequence follows.
- `reset` asserted mid-sequence aborts the sequence immediately and returns the block to the reset values above.

## Timing

All counts below are measured from the first clock edge at which `sel_q` shows a new value.

Switch sequence:
- SETTLE occupies `STABLE_CYCLES` cycles.
- PULSE occupies `RST_CYCLES` cycles; `des_reset[new]` is high for exactly `RST_CYCLES` cycles, starting one cycle after `active_sel` updates.
- `des_io_in[new]` becomes live on the first RUN cycle.
- `io_out` reflects the new slot one cycle after that.
- Total latency from the `sel_q` change to valid `io_out` is `STABLE_CYCLES + RST_CYCLES + 1`.

Other timing rules:
- `switching` is the decoded state, combinational from the state register.
- `hold_q` changes take effect on `des_reset` one cycle after sampling, in any state.
- Simultaneous `sel_q` change and SETTLE expiry: the mismatch wins and the window restarts.

## Configuration

- **`DESMUX_SYNC_EN` defined:**
  - `des_sel` and `hold_if_not_sel` each pass through a two-flop synchronizer before `sel_q`/`hold_q`, giving a 2-cycle sample latency.
  - The synchronizer flops reset to 0 (`hold` path to 1).
- **`DESMUX_SYNC_EN` undefined:** a single sampling register, giving a 1-cycle sample latency.
- The state machine and all other behaviour are identical in both builds.

## Test plan

1. **Reset release.** Release `reset` with `des_sel = 0` and `hold = 1`.
   - `des_reset = all ones` for 8 cycles.
   - Then `des_reset[0] = 0` while the others stay 1.
   - `switching` falls after 8 cycles; `io_out` follows slot 0 one cycle later.
2. **Normal switch.** Change `des_sel` 0→11 with slot 11 driving `12'hA5A`.
   - `active_sel = 11` after 4 SETTLE cycles.
   - `des_reset[11]` is high for exactly 8 cycles.
   - `io_out = 12'hA5A` exactly 13 cycles after the `sel_q` change.
   - `io_out = 0` throughout the switch.
3. **Glitch rejection.** Apply 0→5 for 2 cycles, then back to 0.
   - No `des_reset` pulse occurs.
   - `active_sel` stays 0; `switching` is high for 6 cycles total.
4. **Select change during PULSE.** Switch to 3, and during PULSE change to 7.
   - The pulse on 3 completes in full (8 cycles).
   - One RUN cycle follows, then a new SETTLE and a pulse on 7.
5. **Hold control and unpopulated slot.** Toggle `hold_if_not_sel` to 0 in RUN, then select 63 with `NUM_DESIGNS = 40`.
   - Unselected `des_reset` bits drop to 0.
   - For slot 63, `io_out` stays 0 and no bit is pulsed.
6. **Mid-sequence reset.** Assert `reset` mid-PULSE.
   - All outputs immediately take their reset values without waiting for a clock edge.
   - `active_sel = 0`.
